grb_frame_counter: RTL and testbench

//   Parametrised successor to the 8-bit bit counter. Tracks position within an LED frame as bit-in-LED,
//   LED index and total bits sent, with a programmable strip length and frame auto-rewind.

---
 rtl/grb_frame_counter.sv | 131 +++++++++++++
 tb/tb_grb_frame_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/grb_frame_counter.sv
// rtl/grb_frame_counter.sv - LED frame position counter (bit-in-LED, LED index, total bits)
//
// Tracks the position inside an LED frame for the GRB serialiser FSM.
// Optional feature macro: GRB_CNT_RGBW_EN (per-frame selectable 24/32 bits per LED).
//
// Ports:
//   clk          system clock, all state on posedge
//   reset        asynchronous active-low reset
//   ClearCounter rewind to frame start, latch num_leds (and rgbw)
//   IncCounter   one bit sent, advance position
//   num_leds     strip length, sampled only on ClearCounter
//   rgbw         4-byte LEDs, sampled on ClearCounter (honoured only with GRB_CNT_RGBW_EN)
//   Count        bits sent in current frame
//   BitIdx       bit position inside current LED
//   LedIdx       current LED index
//   LastBit      BitIdx is the final bit of an LED (comb)
//   LastLed      LedIdx is the final LED of the strip (comb)
//   FrameDone    one-cycle pulse after the final bit of the frame was counted
//   Overflow     sticky, Count wrapped past its maximum
module grb_frame_counter #(
   parameter int WIDTH = 16,
   parameter int LED_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ClearCounter,
   input  logic             IncCounter,
   input  logic [LED_W-1:0] num_leds,
   input  logic             rgbw,
   output logic [WIDTH-1:0] Count,
   output logic [4:0]       BitIdx,
   output logic [LED_W-1:0] LedIdx,
   output logic             LastBit,
   output logic             LastLed,
   output logic             FrameDone,
   output logic             Overflow
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [4:0]       bit_idx_q, bit_idx_d;
   logic [LED_W-1:0] led_idx_q, led_idx_d;
   logic [LED_W-1:0] nleds_q, nleds_d;
   logic             rgbw_q, rgbw_d;
   logic             frame_done_q, frame_done_d;
   logic             overflow_q, overflow_d;

   logic [4:0]       bit_last;
   logic [LED_W-1:0] led_last;
   logic             frame_end;

`ifndef GRB_CNT_RGBW_EN
   logic unused_rgbw;
   assign unused_rgbw = rgbw;
`endif

   // A strip length of zero is treated as a single LED.
   assign led_last  = (nleds_q == '0) ? '0 : nleds_q - LED_W'(1);
   assign bit_last  = rgbw_q ? 5'd31 : 5'd23;
   assign LastBit   = (bit_idx_q == bit_last);
   assign LastLed   = (led_idx_q == led_last);
   assign frame_end = LastBit && LastLed;

   always_comb begin
      count_d      = count_q;
      bit_idx_d    = bit_idx_q;
      led_idx_d    = led_idx_q;
      nleds_d      = nleds_q;
      rgbw_d       = rgbw_q;
      overflow_d   = overflow_q;
      frame_done_d = 1'b0;

      if (ClearCounter) begin
         count_d    = '0;
         bit_idx_d  = '0;
         led_idx_d  = '0;
         nleds_d    = num_leds;
`ifdef GRB_CNT_RGBW_EN
         rgbw_d     = rgbw;
`else
         rgbw_d     = 1'b0;
`endif
         overflow_d = 1'b0;
      end else if (IncCounter) begin
         if (frame_end) begin
            // Auto-rewind; strip length and LED type carry over to the next frame.
            count_d      = '0;
            bit_idx_d    = '0;
            led_idx_d    = '0;
            frame_done_d = 1'b1;
         end else begin
            count_d = count_q + WIDTH'(1);
            if (count_q == {WIDTH{1'b1}}) begin
               overflow_d = 1'b1;
            end
            if (LastBit) begin
               bit_idx_d = '0;
               led_idx_d = led_idx_q + LED_W'(1);
            end else begin
               bit_idx_d = bit_idx_q + 5'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q      <= '0;
         bit_idx_q    <= '0;
         led_idx_q    <= '0;
         nleds_q      <= '0;
         rgbw_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         count_q      <= count_d;
         bit_idx_q    <= bit_idx_d;
         led_idx_q    <= led_idx_d;
         nleds_q      <= nleds_d;
         rgbw_q       <= rgbw_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign Count     = count_q;
   assign BitIdx    = bit_idx_q;
   assign LedIdx    = led_idx_q;
   assign FrameDone = frame_done_q;
   assign Overflow  = overflow_q;

endmodule

// File: tb/tb_grb_frame_counter.sv
// tb/tb_grb_frame_counter.sv - randomized and directed bench for grb_frame_counter
module tb_grb_frame_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       clr, inc, rg;
   logic [7:0] nl;

   logic [15:0] a_cnt;
   logic [7:0]  b_cnt;
   logic [4:0]  a_bit, b_bit;
   logic [7:0]  a_led, b_led;
   logic        a_lb, a_ll, a_fd, a_ov;
   logic        b_lb, b_ll, b_fd, b_ov;

   grb_frame_counter #(.WIDTH(16), .LED_W(8)) u_dut16 (
      .clk(clk), .reset(reset), .ClearCounter(clr), .IncCounter(inc),
      .num_leds(nl), .rgbw(rg), .Count(a_cnt), .BitIdx(a_bit), .LedIdx(a_led),
      .LastBit(a_lb), .LastLed(a_ll), .FrameDone(a_fd), .Overflow(a_ov));

   grb_frame_counter #(.WIDTH(8), .LED_W(8)) u_dut8 (
      .clk(clk), .reset(reset), .ClearCounter(clr), .IncCounter(inc),
      .num_leds(nl), .rgbw(rg), .Count(b_cnt), .BitIdx(b_bit), .LedIdx(b_led),
      .LastBit(b_lb), .LastLed(b_ll), .FrameDone(b_fd), .Overflow(b_ov));

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: the frame is a flat sequence of bit slots; position within
   // the frame is a single integer from which every output is derived.
   int pos;
   int m_nleds;
   bit m_rgbw;
   bit m_fd, m_ov8, m_ov16;

   function automatic int m_bpl();
      return m_rgbw ? 32 : 24;
   endfunction

   function automatic int m_n();
      return (m_nleds == 0) ? 1 : m_nleds;
   endfunction

   task automatic model_reset();
      pos = 0; m_nleds = 0; m_rgbw = 0; m_fd = 0; m_ov8 = 0; m_ov16 = 0;
   endtask

   task automatic model_step(input bit c, input bit i, input int n, input bit r);
      m_fd = 0;
      if (c) begin
         pos = 0; m_nleds = n; m_ov8 = 0; m_ov16 = 0;
`ifdef GRB_CNT_RGBW_EN
         m_rgbw = r;
`else
         m_rgbw = 0;
`endif
      end else if (i) begin
         if (pos == m_n() * m_bpl() - 1) begin
            pos = 0; m_fd = 1;
         end else begin
            pos++;
            if (pos >= 256)   m_ov8 = 1;
            if (pos >= 65536) m_ov16 = 1;
         end
      end
   endtask

   task automatic check_all();
      int eb, el;
      eb = pos % m_bpl();
      el = pos / m_bpl();
      chk("cnt16", a_cnt, pos % 65536);
      chk("cnt8",  b_cnt, pos % 256);
      chk("bit16", a_bit, eb);
      chk("bit8",  b_bit, eb);
      chk("led16", a_led, el);
      chk("led8",  b_led, el);
      chk("lastbit", {b_lb, a_lb}, {2{eb == m_bpl() - 1}});
      chk("lastled", {b_ll, a_ll}, {2{el == m_n() - 1}});
      chk("fdone", {b_fd, a_fd}, {2{m_fd}});
      chk("ovf16", a_ov, m_ov16);
      chk("ovf8",  b_ov, m_ov8);
   endtask

   task automatic cycle(input bit c, input bit i, input int n, input bit r);
      clr = c; inc = i; nl = n[7:0]; rg = r;
      @(posedge clk);
      model_step(c, i, n, r);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int n_fd;
      reset = 1'b0; clr = 0; inc = 0; nl = 0; rg = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset = 1'b1;

      // Asynchronous reset mid-count
      cycle(1, 0, 5, 0);
      repeat (37) cycle(0, 1, 5, 0);
      chk("t1_cnt37", a_cnt, 37);
      reset = 1'b0;
      #1;
      chk("t1_rst_cnt", a_cnt, 0);
      chk("t1_rst_bit", a_bit, 0);
      chk("t1_rst_led", a_led, 0);
      chk("t1_rst_fd_ov", {a_fd, a_ov}, 0);
      model_reset();
      #2 reset = 1'b1;

      // Two-LED frame
      cycle(1, 0, 2, 0);
      for (int k = 1; k <= 48; k++) begin
         if (k == 48) chk("t2_last_at47", {a_lb, a_ll}, 2'b11);
         cycle(0, 1, 2, 0);
         if (k == 23) chk("t2_bit23", a_bit, 23);
         if (k == 24) chk("t2_led_step", {a_led, 3'b0, a_bit}, {8'd1, 8'd0});
         if (k == 48) chk("t2_fd48", {a_fd, a_cnt}, {1'b1, 16'd0});
      end
      cycle(0, 0, 2, 0);
      chk("t2_fd_drop", a_fd, 0);

      // num_leds = 0 behaves as a single LED
      cycle(1, 0, 0, 0);
      n_fd = 0;
      for (int k = 1; k <= 24; k++) begin
         chk("t3_lastled", a_ll, 1);
         cycle(0, 1, 0, 0);
         n_fd += a_fd;
      end
      chk("t3_fd_cnt", n_fd, 1);

      // Clear wins over increment
      cycle(1, 0, 7, 0);
      repeat (10) cycle(0, 1, 7, 0);
      cycle(1, 1, 5, 0);
      chk("t4_clr_win", a_cnt, 0);
      for (int k = 1; k <= 120; k++) begin
         cycle(0, 1, 9, 0);
         if (k == 120) chk("t4_n5_fd", a_fd, 1);
      end

      // num_leds changes mid-frame are ignored
      cycle(1, 0, 3, 0);
      n_fd = 0;
      for (int k = 1; k <= 72; k++) begin
         cycle(0, 1, 1, 0);
         n_fd += a_fd;
         if (k == 72) chk("t5_fd72", a_fd, 1);
      end
      chk("t5_fd_once", n_fd, 1);

      // 8-bit count wraps inside a 264-bit frame
      cycle(1, 0, 11, 0);
      for (int k = 1; k <= 264; k++) begin
         cycle(0, 1, 11, 0);
         if (k == 255) chk("t6_no_ovf", b_ov, 0);
         if (k == 256) chk("t6_wrap", {b_ov, b_cnt}, {1'b1, 8'd0});
         if (k == 264) chk("t6_fd_sticky", {b_fd, b_ov}, 2'b11);
      end
      cycle(1, 0, 1, 0);
      chk("t6_ovf_clr", b_ov, 0);

`ifdef GRB_CNT_RGBW_EN
      cycle(1, 0, 1, 1);
      for (int k = 1; k <= 32; k++) begin
         cycle(0, 1, 1, 0);
         if (k == 31) chk("rgbw_bit31", a_bit, 31);
         if (k == 32) chk("rgbw_fd32", a_fd, 1);
      end
`endif

      // Randomized traffic
      for (int k = 0; k < 8000; k++) begin
         int rn;
         rn = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 3);
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, rn, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
